// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage driving one port of the dual-port program memory.
// Issues sequential read addresses, captures read data one cycle later, and
// hands {instr, instr_pc} to decode over valid/ready through a 2-entry buffer.
// Branch/jump redirects reload the PC and flush the buffer and any in-flight read.
//
// Ports:
//   clk, rst          clock (also clocks the memory port), synchronous active-high reset
//   mem_addr          read address, equal to the pc register
//   mem_we, mem_din   write side of the memory port, tied off
//   mem_dout          read data, valid one cycle after the address
//   redirect_valid    load redirect_pc and flush
//   redirect_pc       redirect target
//   instr_valid       buffer head holds an instruction
//   instr, instr_pc   head instruction word and its address
//   instr_ready       decode accepts the head this cycle
module instr_fetch #(
  parameter int unsigned       ADDR_W   = 12,
  parameter int unsigned       DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
);

  logic [ADDR_W-1:0] r_pc;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_inflight_pc;

  // Shift-style buffer: entry 0 is always the head, so outputs come straight from flops.
  logic              r_v0, r_v1;
  logic [DATA_W-1:0] r_d0, r_d1;
  logic [ADDR_W-1:0] r_p0, r_p1;

  logic              w_pop;
  logic              w_push;
  logic              w_issue;
  logic              w_overflow;
  logic [1:0]        w_count;
  logic [2:0]        w_occ;
  logic              w_v0, w_v1;
  logic [DATA_W-1:0] w_d0, w_d1;
  logic [ADDR_W-1:0] w_p0, w_p1;

  assign mem_addr    = r_pc;
  assign mem_we      = 1'b0;
  assign mem_din     = '0;
  assign instr_valid = r_v0;
  assign instr       = r_d0;
  assign instr_pc    = r_p0;

  // Issue only if buffered + in-flight entries still fit after this cycle's pop.
  always_comb begin
    w_pop   = r_v0 & instr_ready;
    w_push  = r_inflight & ~redirect_valid;
    w_count = 2'({1'b0, r_v0} + {1'b0, r_v1});
    w_occ   = 3'(w_count) + 3'(r_inflight) - 3'(w_pop);
    w_issue = ~rst & ~redirect_valid & (w_occ < 3'd2);
    // Full after the pop means entry 1 is still occupied.
    w_overflow = w_push & ~w_pop & r_v1;
  end

  // Next buffer contents: pop shifts entry 1 forward, push fills the first free slot.
  always_comb begin
    w_v0 = r_v0;
    w_v1 = r_v1;
    w_d0 = r_d0;
    w_d1 = r_d1;
    w_p0 = r_p0;
    w_p1 = r_p1;
    if (w_pop) begin
      w_v0 = r_v1;
      w_d0 = r_d1;
      w_p0 = r_p1;
      w_v1 = 1'b0;
    end
    if (w_push) begin
      if (!w_v0) begin
        w_v0 = 1'b1;
        w_d0 = mem_dout;
        w_p0 = r_inflight_pc;
      end else begin
        w_v1 = 1'b1;
        w_d1 = mem_dout;
        w_p1 = r_inflight_pc;
      end
    end
  end

  // PC, in-flight tracking and buffer state; reset beats redirect beats normal flow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_v0          <= 1'b0;
      r_v1          <= 1'b0;
      r_d0          <= '0;
      r_d1          <= '0;
      r_p0          <= '0;
      r_p1          <= '0;
    end else if (redirect_valid) begin
      r_pc       <= redirect_pc;
      r_inflight <= 1'b0;
      r_v0       <= 1'b0;
      r_v1       <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_pc          <= r_pc + ADDR_W'(1);
        r_inflight_pc <= r_pc;
      end
      r_v0 <= w_v0;
      r_v1 <= w_v1;
      r_d0 <= w_d0;
      r_d1 <= w_d1;
      r_p0 <= w_p0;
      r_p1 <= w_p1;
    end
  end

  // The issue rule must keep pushes from landing in a full buffer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!w_overflow);
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [11:0] redirect_pc;
  logic        instr_ready;

  logic [11:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;
  logic        instr_valid;
  logic [15:0] instr;
  logic [11:0] instr_pc;

  logic [11:0] w_mem_addr;
  logic        w_mem_we;
  logic [15:0] w_mem_din;
  logic [15:0] w_mem_dout;
  logic        w_instr_valid;
  logic [15:0] w_instr;
  logic [11:0] w_instr_pc;

  logic [15:0] mem [4096];

  instr_fetch #(.ADDR_W(12), .DATA_W(16), .RESET_PC(12'h000)) u_dut (
    .clk(clk), .rst(rst),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready)
  );

  // Second instance starting near the top of the address space, always ready.
  instr_fetch #(.ADDR_W(12), .DATA_W(16), .RESET_PC(12'hFFE)) u_dut_w (
    .clk(clk), .rst(rst),
    .mem_addr(w_mem_addr), .mem_we(w_mem_we), .mem_din(w_mem_din), .mem_dout(w_mem_dout),
    .redirect_valid(1'b0), .redirect_pc(12'h000),
    .instr_valid(w_instr_valid), .instr(w_instr), .instr_pc(w_instr_pc), .instr_ready(1'b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read program memory, one cycle latency.
  initial for (int i = 0; i < 4096; i++) mem[i] = 16'hA000 + 16'(i);
  always @(posedge clk) begin
    mem_dout   <= mem[mem_addr];
    w_mem_dout <= mem[w_mem_addr];
  end

  // Scoreboard: expected PC stream, written only by stimulus; monitor owns rd_idx.
  logic [11:0] exp_q[$];
  int          flush_idx = 0;
  int          rd_idx    = 0;

  int n_cmp = 0;
  int n_err = 0;
  int n_pops = 0;
  int wrap_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus side: records what the previous cycle's inputs imply for the stream.
  logic        p_rst = 1'b1;
  logic        p_rv  = 1'b0;
  logic [11:0] p_rpc = 12'h000;

  task automatic step(input logic r, input logic rdy, input logic rv, input logic [11:0] rpc);
    int need;
    @(posedge clk);
    #1;
    if (p_rst || p_rv) begin
      flush_idx = exp_q.size();
      exp_q.push_back(p_rst ? 12'h000 : p_rpc);
    end
    need = ((rd_idx > flush_idx) ? rd_idx : flush_idx) + 8;
    while (exp_q.size() < need) exp_q.push_back(exp_q[$] + 12'd1);
    rst            = r;
    instr_ready    = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    p_rst = r;
    p_rv  = rv;
    p_rpc = rpc;
  endtask

  initial begin
    logic        r, rdy, rv;
    logic [11:0] tgt;
    rst = 1'b1;
    instr_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 12'h000;
    repeat (3) step(1'b1, 1'b1, 1'b0, 12'h000);
    repeat (9) step(1'b0, 1'b1, 1'b0, 12'h000);
    repeat (5) step(1'b0, 1'b0, 1'b0, 12'h000);
    repeat (6) step(1'b0, 1'b1, 1'b0, 12'h000);
    step(1'b0, 1'b0, 1'b0, 12'h000);
    step(1'b0, 1'b0, 1'b1, 12'h100);
    repeat (8) step(1'b0, 1'b1, 1'b0, 12'h000);
    step(1'b0, 1'b1, 1'b1, 12'h200);
    repeat (6) step(1'b0, 1'b1, 1'b0, 12'h000);
    step(1'b0, 1'b1, 1'b1, 12'h300);
    step(1'b0, 1'b1, 1'b1, 12'hFFD);
    repeat (8) step(1'b0, 1'b1, 1'b0, 12'h000);
    step(1'b1, 1'b0, 1'b0, 12'h000);
    repeat (6) step(1'b0, 1'b1, 1'b0, 12'h000);
    for (int n = 0; n < 3000; n++) begin
      r   = ($urandom_range(0, 299) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 11) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? 12'hFFE : 12'($urandom);
      step(r, rdy, rv, tgt);
    end
    repeat (6) step(1'b0, 1'b1, 1'b0, 12'h000);
    @(negedge clk);
    #1;
    chk("enough_pops", 32'(n_pops > 500), 32'd1);
    chk("wrap_seen", 32'(wrap_seen > 0), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Monitor: samples mid-cycle, checks timing, handshake stream and reset state.
  int          k = 0;
  logic        m_prev_rst = 1'b1;
  logic        m_hold = 1'b0;
  logic [15:0] m_instr;
  logic [11:0] m_pc;
  logic [11:0] exp_w = 12'hFFE;

  always @(negedge clk) begin
    if (m_prev_rst) begin
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", 32'(instr), 32'd0);
      chk("rst_pc", 32'(instr_pc), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'h000);
      chk("rst_addr_w", 32'(w_mem_addr), 32'hFFE);
      chk("rst_valid_w", 32'(w_instr_valid), 32'd0);
    end
    chk("mem_we", 32'({mem_we, w_mem_we}), 32'd0);
    chk("mem_din", 32'(mem_din | w_mem_din), 32'd0);
    if (rst) begin
      k = 0;
    end else begin
      if (k < 100) k++;
      chk("valid_timing", 32'(instr_valid), 32'(k >= 3));
      if (m_hold) begin
        chk("hold_instr", 32'(instr), 32'(m_instr));
        chk("hold_pc", 32'(instr_pc), 32'(m_pc));
      end
      if (rd_idx < flush_idx) rd_idx = flush_idx;
      if (instr_valid && instr_ready) begin
        if (rd_idx >= exp_q.size()) begin
          n_cmp++;
          n_err++;
          $display("FAIL stream: pop of pc %0h with no expected entry", instr_pc);
        end else begin
          chk("stream_pc", 32'(instr_pc), 32'(exp_q[rd_idx]));
          chk("stream_instr", 32'(instr), 32'(16'hA000 + 16'(exp_q[rd_idx])));
          rd_idx++;
        end
        n_pops++;
      end
      if (redirect_valid) k = 0;
    end
    m_hold  = !rst && !redirect_valid && instr_valid && !instr_ready;
    m_instr = instr;
    m_pc    = instr_pc;

    if (rst) begin
      exp_w = 12'hFFE;
    end else if (w_instr_valid) begin
      chk("wrap_pc", 32'(w_instr_pc), 32'(exp_w));
      chk("wrap_instr", 32'(w_instr), 32'(16'hA000 + 16'(exp_w)));
      if (exp_w == 12'h000) wrap_seen++;
      exp_w = exp_w + 12'd1;
    end
    m_prev_rst = rst;
  end

endmodule
